// File: rtl/sort_mon_pkg.sv
// Shared types and helpers for the sort result monitor: FSM states, width
// helper and the element ordering compare.
package sort_mon_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    // Widest data word the ordering compare accepts; callers zero-extend.
    localparam int CMP_W = 256;

    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Unsigned a <= b; signed ordering is obtained by the caller flipping the
    // sign bit of both operands before the call.
    function automatic logic word_le(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
        return a <= b;
    endfunction

endpackage

// File: rtl/sort_mon_window.sv
// Address decode of the watched array window plus the element capture
// registers; exposes both the registered words and their next-edge values.
module sort_mon_window
    import sort_mon_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              ADDR_W    = 64,
    parameter int              NUM_ELEM  = 3,
    parameter longint unsigned BASE_ADDR = 0,
    parameter longint unsigned STRIDE    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture_en,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       hit,
    output logic [NUM_ELEM*DATA_W-1:0] elements,
    output logic [NUM_ELEM*DATA_W-1:0] elements_nxt
);

    localparam int              SH     = clog2(STRIDE);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SPAN_A = ADDR_W'(longint'(NUM_ELEM) * STRIDE);
    localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(STRIDE - 1);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_off;

    // Addresses below BASE wrap to a large offset, so a single bound check
    // covers both window edges as long as BASE+span does not wrap.
    assign offset   = mem_addr - BASE_A;
    assign word_off = offset >> SH;
    assign hit      = mem_we && (offset < SPAN_A) && ((offset & MASK_A) == '0);

    always_comb begin
        elements_nxt = elements;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (capture_en && hit && (word_off == ADDR_W'(i))) begin
                elements_nxt[i*DATA_W +: DATA_W] = mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            elements <= '0;
        end else begin
            elements <= elements_nxt;
        end
    end

endmodule

// File: rtl/sort_result_monitor.sv
// Run monitor beside the core: sequences core reset, captures the array
// window, detects completion and reports sortedness. Option: SORT_SIGNED_EN.
module sort_result_monitor
    import sort_mon_pkg::*;
#(
    parameter int              DATA_W       = 64,
    parameter int              ADDR_W       = 64,
    parameter int              NUM_ELEM     = 3,
    parameter longint unsigned BASE_ADDR    = 0,
    parameter longint unsigned STRIDE       = 8,
    parameter int              RST_HOLD     = 3,
    parameter int              QUIET_CYCLES = 16,
    parameter longint unsigned MAX_CYCLES   = 100000,
    parameter int              CYC_W        = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       core_reset,
    output logic [NUM_ELEM*DATA_W-1:0] elements,
    output logic                       done,
    output logic                       timeout,
    output logic                       sorted_ok,
    output logic [CYC_W-1:0]           cycle_count,
    output logic [7:0]                 write_count
);

    localparam int HOLD_W  = (clog2(RST_HOLD + 1) < 1) ? 1 : clog2(RST_HOLD + 1);
    localparam int QUIET_W = (clog2(QUIET_CYCLES + 1) < 1) ? 1 : clog2(QUIET_CYCLES + 1);
    localparam longint unsigned SPAN = longint'(NUM_ELEM) * STRIDE;
    localparam logic [CYC_W-1:0]   MAX_C   = CYC_W'(MAX_CYCLES);
    localparam logic [QUIET_W-1:0] QUIET_C = QUIET_W'(QUIET_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    if (NUM_ELEM < 1) begin : g_chk_num
        $error("NUM_ELEM must be at least 1");
    end
    if (RST_HOLD < 1) begin : g_chk_hold
        $error("RST_HOLD must be at least 1");
    end
    if ((STRIDE == 0) || ((STRIDE & (STRIDE - 1)) != 0)) begin : g_chk_stride
        $error("STRIDE must be a power of two");
    end
    if ((ADDR_W < 64) && ((BASE_ADDR + SPAN) > (64'd1 << ADDR_W))) begin : g_chk_span
        $error("NUM_ELEM*STRIDE window overflows ADDR_W");
    end
    if ((CYC_W < 64) && (MAX_CYCLES > ((64'd1 << CYC_W) - 1))) begin : g_chk_max
        $error("MAX_CYCLES does not fit in CYC_W");
    end
    if (DATA_W > CMP_W) begin : g_chk_data
        $error("DATA_W exceeds supported compare width");
    end

    mon_state_t state;
    mon_state_t state_nxt;

    logic [HOLD_W-1:0]          hold_cnt;
    logic [QUIET_W-1:0]         quiet_cnt;
    logic [CYC_W-1:0]           cyc_inc;
    logic                       hit;
    logic                       quiet_hit;
    logic                       timeout_hit;
    logic                       sorted_nxt;
    logic [NUM_ELEM*DATA_W-1:0] elements_nxt;

    sort_mon_window #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_ELEM (NUM_ELEM),
        .BASE_ADDR(BASE_ADDR),
        .STRIDE   (STRIDE)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .capture_en  (state == RUN),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .hit         (hit),
        .elements    (elements),
        .elements_nxt(elements_nxt)
    );

`ifdef SORT_SIGNED_EN
    localparam logic [DATA_W-1:0] SIGN_BIT = DATA_W'(1) << (DATA_W - 1);

    function automatic logic [CMP_W-1:0] cmp_key(input logic [DATA_W-1:0] w);
        return CMP_W'(w ^ SIGN_BIT);
    endfunction
`else
    function automatic logic [CMP_W-1:0] cmp_key(input logic [DATA_W-1:0] w);
        return CMP_W'(w);
    endfunction
`endif

    // Judged on next-edge element values so a capture on the exit cycle counts.
    always_comb begin
        sorted_nxt = 1'b1;
        for (int i = 0; i < NUM_ELEM - 1; i++) begin
            if (!word_le(cmp_key(elements_nxt[i*DATA_W +: DATA_W]),
                         cmp_key(elements_nxt[(i+1)*DATA_W +: DATA_W]))) begin
                sorted_nxt = 1'b0;
            end
        end
    end

    assign cyc_inc     = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    assign timeout_hit = (cyc_inc >= MAX_C);
    assign quiet_hit   = (write_count != 8'd0) && (quiet_cnt == QUIET_C);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
            RUN:  if (quiet_hit || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = DONE;
            default: state_nxt = HOLD;
        endcase
    end

    always_comb begin
        core_reset = (state == HOLD);
        done       = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt    <= '0;
            quiet_cnt   <= '0;
            cycle_count <= '0;
            write_count <= '0;
            timeout     <= 1'b0;
            sorted_ok   <= 1'b0;
        end else begin
            case (state)
                HOLD: hold_cnt <= hold_cnt + 1'b1;
                RUN: begin
                    cycle_count <= cyc_inc;
                    if (hit) begin
                        write_count <= (write_count == 8'hff) ? write_count : write_count + 8'd1;
                        quiet_cnt   <= '0;
                    end else if ((write_count != 8'd0) && (quiet_cnt != QUIET_C)) begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                    // Quiescence outranks a coincident timeout.
                    if (state_nxt == DONE) begin
                        timeout   <= timeout_hit && !quiet_hit;
                        sorted_ok <= sorted_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_result_monitor.sv
// Directed bench for sort_result_monitor (MAX_CYCLES=50, other defaults);
// hand-computed expectations checked with immediate assertions.
module tb_sort_result_monitor;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NE = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           mem_we = 1'b0;
    logic [AW-1:0]  mem_addr = '0;
    logic [DW-1:0]  mem_wdata = '0;
    logic           core_reset;
    logic [NE*DW-1:0] elements;
    logic           done;
    logic           timeout;
    logic           sorted_ok;
    logic [31:0]    cycle_count;
    logic [7:0]     write_count;

    int check_cnt = 0;
    int pass_cnt = 0;
    int n;
    logic exp_signed_sorted;

    sort_result_monitor #(
        .MAX_CYCLES(50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .elements   (elements),
        .done       (done),
        .timeout    (timeout),
        .sorted_ok  (sorted_ok),
        .cycle_count(cycle_count),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
    endtask

    // Releases reset and counts cycles with core_reset high (expect 3).
    task automatic release_reset(input string tag);
        int k;
        reset = 1'b1;
        k = 0;
        while (core_reset && k < 10) begin
            tick();
            k++;
        end
        check({tag, "_hold_len"}, k, 3);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 120) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        exp_signed_sorted = 1'b0;
`ifdef SORT_SIGNED_EN
        exp_signed_sorted = 1'b1;
`endif

        // Reset state
        apply_reset();
        check("rst_core_reset", core_reset, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_sorted", sorted_ok, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_writes", write_count, 0);
        check("rst_elements", elements, 0);
        release_reset("rel1");
        check("run_cycles_start", cycle_count, 0);

        // Sorted array: 5, 9, 12
        write(64'h0, 64'd5);
        check("elem0_latency", elements[0 +: DW], 5);
        write(64'h8, 64'd9);
        write(64'h10, 64'd12);
        wait_done(n);
        check("quiet_latency", n, 17);
        check("sorted_done", done, 1);
        check("sorted_ok", sorted_ok, 1);
        check("sorted_timeout", timeout, 0);
        check("sorted_writes", write_count, 3);
        check("sorted_cycles", cycle_count, 20);
        check("sorted_elements", elements, {64'd12, 64'd9, 64'd5});
        write(64'h0, 64'd99);
        check("done_frozen_elem", elements, {64'd12, 64'd9, 64'd5});
        check("done_frozen_writes", write_count, 3);
        check("done_frozen_cycles", cycle_count, 20);
        check("done_core_reset", core_reset, 0);

        // Unsorted array: 9, 5, 12
        apply_reset();
        check("rst2_done", done, 0);
        check("rst2_elements", elements, 0);
        release_reset("rel2");
        write(64'h0, 64'd9);
        write(64'h8, 64'd5);
        write(64'h10, 64'd12);
        wait_done(n);
        check("unsorted_latency", n, 17);
        check("unsorted_ok", sorted_ok, 0);
        check("unsorted_timeout", timeout, 0);

        // Misaligned and out-of-window writes, then timeout
        apply_reset();
        release_reset("rel3");
        write(64'h4, 64'd7);
        write(64'h18, 64'd8);
        check("ignored_elements", elements, 0);
        check("ignored_writes", write_count, 0);
        wait_done(n);
        check("timeout_latency", n, 48);
        check("timeout_done", done, 1);
        check("timeout_flag", timeout, 1);
        check("timeout_cycles", cycle_count, 50);
        check("timeout_writes", write_count, 0);
        check("timeout_sorted_zero", sorted_ok, 1);

        // Reset in the middle of RUN
        apply_reset();
        release_reset("rel4");
        write(64'h8, 64'd33);
        check("midrun_elem1", elements[DW +: DW], 33);
        check("midrun_writes", write_count, 1);
        reset = 1'b0;
        tick();
        check("midrun_rst_core", core_reset, 1);
        check("midrun_rst_elem", elements, 0);
        check("midrun_rst_writes", write_count, 0);
        check("midrun_rst_cycles", cycle_count, 0);
        check("midrun_rst_done", done, 0);
        release_reset("rel5");

        // Negative element: signed vs unsigned ordering
        write(64'hffff_ffff_ffff_ffff, 64'd0);
        write(64'h0, 64'hffff_ffff_ffff_ffff);
        write(64'h8, 64'd3);
        write(64'h10, 64'd5);
        wait_done(n);
        check("signed_done", done, 1);
        check("signed_sorted", sorted_ok, exp_signed_sorted);

        // Capture on the timeout exit cycle
        apply_reset();
        release_reset("rel6");
        for (int i = 0; i < 49; i++) tick();
        check("exit_pre_cycles", cycle_count, 49);
        check("exit_pre_done", done, 0);
        write(64'h10, 64'd77);
        check("exit_done", done, 1);
        check("exit_timeout", timeout, 1);
        check("exit_elem2", elements[2*DW +: DW], 77);
        check("exit_writes", write_count, 1);
        check("exit_sorted", sorted_ok, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sort_result_monitor.md
Name: sort_result_monitor

Overview:
Parametrised on-chip run monitor for RISC_V_Processor. It replaces the fixed three-element observation and hand-driven reset pulse with synthesizable logic.
- Sequences the core's reset.
- Snoops data-memory writes into a window of NUM_ELEM words.
- Detects program completion by write quiescence or timeout, then reports a sortedness verdict and a cycle count.
- Sits beside the processor, tapping the data-memory write port; its outputs feed the bench or LEDs.

Parameters:
DATA_W, 64, data word width
ADDR_W, 64, memory address width
NUM_ELEM, 3, number of watched array elements (>=1)
BASE_ADDR, 0, byte address of element 0
STRIDE, 8, byte spacing between elements (power of two)
RST_HOLD, 3, cycles core_reset is held asserted after monitor reset (>=1)
QUIET_CYCLES, 16, write-free cycles in the window that declare completion
MAX_CYCLES, 100000, run-cycle timeout
CYC_W, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
mem_we  in  1  core data-memory write strobe
mem_addr  in  ADDR_W  core data-memory byte address
mem_wdata  in  DATA_W  core data-memory write data
core_reset  out  1  active-high reset driven to RISC_V_Processor
elements  out  NUM_ELEM*DATA_W  captured words; element i at bits [i*DATA_W +: DATA_W]
done  out  1  run finished (sticky until reset)
timeout  out  1  run ended by MAX_CYCLES
sorted_ok  out  1  elements non-decreasing; valid when done=1
cycle_count  out  CYC_W  cycles spent in RUN
write_count  out  8  in-window writes seen, saturating at 255

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=HOLD, core_reset=1, elements=0, done=0, timeout=0, sorted_ok=0.
  - cycle_count=0, write_count=0, hold and quiet counters=0.
  - Reset mid-run aborts everything and restarts HOLD.
- FSM states: HOLD, RUN, DONE.
- HOLD:
  - core_reset=1 for exactly RST_HOLD cycles after reset deasserts, then RUN.
  - core_reset falls on the same edge that enters RUN.
  - Writes during HOLD are ignored.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - A write is in-window when mem_we=1, BASE_ADDR <= mem_addr < BASE_ADDR+NUM_ELEM*STRIDE, and mem_addr[log2(STRIDE)-1:0]==0.
  - In-window write: element idx=(mem_addr-BASE_ADDR)>>log2(STRIDE) gets mem_wdata on the next edge, write_count++ (saturating), quiet counter cleared.
  - Out-of-window or misaligned writes are ignored and do not clear the quiet counter.
  - Otherwise the quiet counter increments, but only once write_count>0.
  - Quiet counter reaching QUIET_CYCLES: go to DONE with timeout=0.
  - cycle_count reaching MAX_CYCLES first: go to DONE with timeout=1.
  - If both occur on the same cycle, timeout=0 (quiescence wins).
  - A capture write on the exit cycle is still captured.
- DONE:
  - done=1, core_reset stays 0, counters frozen, elements frozen; further writes are ignored.
  - sorted_ok is registered on DONE entry: 1 iff element[i] <= element[i+1] for all i.
  - NUM_ELEM=1 gives sorted_ok=1.
  - Comparison is unsigned unless SORT_SIGNED_EN is defined.
- Latency:
  - Write to elements update: 1 cycle.
  - Last in-window write to done: QUIET_CYCLES+1 cycles.
- Bound: NUM_ELEM*STRIDE must not overflow ADDR_W (elaboration assertion).

Optional Feature:
SORT_SIGNED_EN:
- Defined: sortedness uses two's-complement signed comparison of DATA_W words.
- Undefined: unsigned comparison.
- Ports and timing are identical in both cases.

Decomposition:
- Package sort_mon_pkg: state enum (HOLD/RUN/DONE), index-width function clog2, sortedness-compare function.
- One natural sub-module, sort_mon_window: a combinational-plus-register address decode and element capture array (in-window flag, index, element storage).
- The FSM and counters live in the top.

Test Plan:
- Reset held low 2 cycles, then released -> core_reset=1 for exactly 3 cycles, falls entering RUN; all outputs 0.
- Writes to 0x0=5, 0x8=9, 0x10=12, then idle -> elements={12,9,5} (elem0=5); done rises 17 cycles after the last write; sorted_ok=1; write_count=3.
- Writes 0x0=9, 0x8=5, 0x10=12 -> sorted_ok=0.
- Writes to 0x4 (misaligned) and 0x18 (out of window) -> elements unchanged, write_count=0, no done before timeout.
- No in-window writes with MAX_CYCLES=50 -> done=1 and timeout=1 at cycle_count=50.
- reset driven low mid-RUN after one write, then released -> all state cleared and HOLD restarts.
- With SORT_SIGNED_EN and elements {-1,3}: sorted_ok=1; without it: sorted_ok=0.
